// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit the clock, request-to-send, clock one byte out, take the ACK.
// Define PS2_TX_ACK_CHECK_EN to report a device NACK through oErr instead of completing normally.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int REQ_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DAT_OE
);

  localparam int MAX_A      = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} stateT;

  stateT         state, stateNxt;
  logic [TW-1:0] timer, timerNxt;
  logic [3:0]    count, countNxt;
  logic [9:0]    frame, frameNxt;
  logic          doneNxt, errNxt, clkOeNxt, datOeNxt;
  logic          clkS1, clkS2, clkPrev, datS1, datS2, fall;

  // Pin synchronisers; the registered fall strobe lands three edges after the pin settles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clkS1   <= 1'b1;
      clkS2   <= 1'b1;
      clkPrev <= 1'b1;
      datS1   <= 1'b1;
      datS2   <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clkS1   <= iPS2_CLK;
      clkS2   <= clkS1;
      clkPrev <= clkS2;
      datS1   <= iPS2_DAT;
      datS2   <= datS1;
      fall    <= clkPrev & ~clkS2;
    end
  end

  // One timer serves the inhibit hold, the request overlap and the transfer watchdog.
  always_comb begin
    stateNxt = state;
    timerNxt = timer;
    countNxt = count;
    frameNxt = frame;
    doneNxt  = 1'b0;
    errNxt   = 1'b0;
    case (state)
      IDLE: begin
        if (iSend) begin
          frameNxt = {~^iData, iData, 1'b0};
          timerNxt = '0;
          countNxt = '0;
          stateNxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer == TW'(INHIBIT_CYCLES - 1)) begin
          timerNxt = '0;
          stateNxt = REQ;
        end else begin
          timerNxt = timer + 1'b1;
        end
      end
      REQ: begin
        if (timer == TW'(REQ_CYCLES - 1)) begin
          timerNxt = '0;
          stateNxt = SEND;
        end else begin
          timerNxt = timer + 1'b1;
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        timerNxt = timer + 1'b1;
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end else if (state == SEND) begin
          if (fall) begin
            countNxt = count + 4'd1;
            if (count == 4'd9) stateNxt = ACK;
          end
        end else if (state == ACK) begin
          if (fall) begin
            countNxt = count + 4'd1;
`ifdef PS2_TX_ACK_CHECK_EN
            if (datS2) begin
              errNxt   = 1'b1;
              stateNxt = IDLE;
            end else begin
              stateNxt = WAIT_IDLE;
            end
`else
            stateNxt = WAIT_IDLE;
`endif
          end
        end else if (clkS2 && datS2) begin
          doneNxt  = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Line drives follow the next state so they change on the same edge as the FSM; a 1 bit is a release.
  always_comb begin
    clkOeNxt = (stateNxt == INHIBIT) || (stateNxt == REQ);
    datOeNxt = (stateNxt == REQ) ||
               ((stateNxt == SEND) && (countNxt < 4'd10) && !frameNxt[countNxt]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      count       <= '0;
      frame       <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oErr        <= 1'b0;
      oPS2_CLK_OE <= 1'b0;
      oPS2_DAT_OE <= 1'b0;
    end else begin
      state       <= stateNxt;
      timer       <= timerNxt;
      count       <= countNxt;
      frame       <= frameNxt;
      oBusy       <= (stateNxt != IDLE);
      oDone       <= doneNxt;
      oErr        <= errNxt;
      oPS2_CLK_OE <= clkOeNxt;
      oPS2_DAT_OE <= datOeNxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// cycle-by-cycle reference derived from the transfer timeline checks every output.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int REQC = 8;
  localparam int TO   = 1500;
  localparam int HALF = 20;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iSend = 1'b0;
  logic       oBusy, oDone, oErr, oPS2_CLK_OE, oPS2_DAT_OE;
  logic       devClkLow = 1'b0;
  logic       devDatLow = 1'b0;
  logic       psClk, psDat;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int k = 0;
  bit armed = 1'b0;
  bit modelActive = 1'b0;
  bit sendSeen = 1'b0;
  bit rstSeen = 1'b1;
  logic [4:0] cmpOuts;

  // Open-drain wired-AND of host and device on both lines.
  assign psClk = ~oPS2_CLK_OE & ~devClkLow;
  assign psDat = ~oPS2_DAT_OE & ~devDatLow;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .iData      (iData),
    .iSend      (iSend),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oErr       (oErr),
    .iPS2_CLK   (psClk),
    .iPS2_DAT   (psDat),
    .oPS2_CLK_OE(oPS2_CLK_OE),
    .oPS2_DAT_OE(oPS2_DAT_OE)
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame as the device must see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frameOf(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  always @(posedge clk) begin
    sendSeen <= iSend;
    rstSeen  <= !reset_n;
  end

  always @(negedge clk) begin
    if (oDone === 1'b1) doneCnt++;
    if (oErr === 1'b1) errCnt++;
  end

  // Reference timeline: k counts edges since acceptance; hold phase and watchdog edge are fixed.
  always @(negedge clk) begin
    if (rstSeen) modelActive = 1'b0;
    else if (modelActive) k++;
    else if (sendSeen) begin
      modelActive = 1'b1;
      k = 1;
    end
    if (armed) begin
      cmpOuts = {oBusy, oPS2_CLK_OE, oPS2_DAT_OE, oDone, oErr};
      if (!modelActive)
        checkOutput("idleOuts", 32'(cmpOuts), 32'd0);
      else if (k <= INH + REQC)
        checkOutput("holdOuts", 32'(cmpOuts), 32'({1'b1, 1'b1, (k > INH), 1'b0, 1'b0}));
      else if (k == INH + REQC + 1 + TO) begin
        checkOutput("timeoutEdge", 32'(cmpOuts), 32'b00001);
        modelActive = 1'b0;
      end else if (oDone === 1'b1 || oErr === 1'b1) begin
        checkOutput("finishOuts", 32'({oBusy, oPS2_CLK_OE, oPS2_DAT_OE, oDone & oErr}), 32'd0);
        modelActive = 1'b0;
      end else
        checkOutput("sendOuts", 32'({oBusy, oPS2_CLK_OE, oDone, oErr}), 32'b1000);
    end
  end

  task automatic deviceFrame(input bit nack, input int injectAt, input int resetAt,
                             output logic [10:0] bits, output bit ok);
    int w;
    bits = '0;
    ok = 1'b0;
    w = 0;
    while (!(psClk === 1'b1 && psDat === 1'b0) && w < 4 * (INH + REQC)) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4 * (INH + REQC)) return;
    bits[0] = psDat;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        devDatLow = !nack;
        repeat (HALF) @(negedge clk);
      end
      devClkLow = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (i == injectAt && c == 2) begin
          iData = 8'h55;
          iSend = 1'b1;
        end else
          iSend = 1'b0;
      end
      if (i <= 10) bits[i] = psDat;
      if (i == resetAt) begin
        devClkLow = 1'b0;
        devDatLow = 1'b0;
        ok = 1'b1;
        return;
      end
      devClkLow = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    devDatLow = 1'b0;
    ok = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit nack, input int injectAt,
                               input int resetAt, input bit holdSend, input string tag);
    logic [10:0] bits;
    logic [10:0] expFrame;
    bit ok;
    int w, d0, e0;
    d0 = doneCnt;
    e0 = errCnt;
    expFrame = frameOf(b);
    @(negedge clk);
    iData = b;
    iSend = 1'b1;
    @(negedge clk);
    iSend = 1'b0;
    iData = 8'($urandom);
    deviceFrame(nack, injectAt, resetAt, bits, ok);
    checkOutput({tag, "_devStart"}, 32'(ok), 32'd1);
    if (resetAt > 0) begin
      checkOutput({tag, "_partial"}, 32'(bits[4:0]), 32'(expFrame[4:0]));
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_resetOuts"},
                  32'({oBusy, oPS2_CLK_OE, oPS2_DAT_OE, oDone, oErr}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_noPulse"}, 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);
      return;
    end
    checkOutput({tag, "_frame"}, 32'(bits), 32'(expFrame));
    w = 0;
    while (w < 400) begin
      @(negedge clk);
      if (oBusy !== 1'b1) break;
      iSend = holdSend;
      w++;
    end
    iSend = 1'b0;
    checkOutput({tag, "_completeInTime"}, 32'(w < 400), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(doneCnt - d0), 32'(!(nack && ACK_CHECK)));
    checkOutput({tag, "_err"}, 32'(errCnt - e0), 32'(nack && ACK_CHECK));
  endtask

  task automatic timeoutTest(input logic [7:0] b);
    int w, d0, e0;
    d0 = doneCnt;
    e0 = errCnt;
    @(negedge clk);
    iData = b;
    iSend = 1'b1;
    @(negedge clk);
    iSend = 1'b0;
    w = 1;
    while (oErr !== 1'b1 && w < INH + REQC + TO + 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("timeout_latency", 32'(w), 32'(INH + REQC + 1 + TO));
    checkOutput("timeout_lines", 32'({oBusy, oPS2_CLK_OE, oPS2_DAT_OE}), 32'd0);
    @(negedge clk);
    checkOutput("timeout_err", 32'(errCnt - e0), 32'd1);
    checkOutput("timeout_done", 32'(doneCnt - d0), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    bit rnack;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    checkOutput("resetOuts", 32'({oBusy, oPS2_CLK_OE, oPS2_DAT_OE, oDone, oErr}), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("pinModelED", 32'(frameOf(8'hED)), 32'h7DA);
    checkOutput("pinModel00", 32'(frameOf(8'h00)), 32'h600);
    checkOutput("pinModelFF", 32'(frameOf(8'hFF)), 32'h7FE);
    checkOutput("pinModelF4", 32'(frameOf(8'hF4)), 32'h5E8);

    applyStimulus(8'hED, 1'b0, 0, 0, 1'b0, "sendED");
    applyStimulus(8'h00, 1'b0, 0, 0, 1'b1, "send00");
    applyStimulus(8'hFF, 1'b1, 0, 0, 1'b0, "nackFF");
    timeoutTest(8'hF4);
    applyStimulus(8'hED, 1'b0, 3, 0, 1'b0, "busyReq");
    applyStimulus(8'hED, 1'b0, 0, 4, 1'b0, "midReset");
    applyStimulus(8'hED, 1'b0, 0, 0, 1'b0, "afterReset");

    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      rnack = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      applyStimulus(rb, rnack, 0, 0, 1'($urandom_range(0, 1)), "random");
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
